// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline sequencing controller: controller state and register index.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } hz_state_t;

  typedef logic [4:0] regbits_t;

endpackage

// File: rtl/pl_hazard_ctrl_if.sv
// Hazard-controller bundle: stage status from the datapath in, pipe-register controls out.
// Handshake: no valid/ready pairs here; every control is a same-cycle level the datapath samples at the next rising CLK.
interface pl_hazard_ctrl_if;
  import cpu_types_pkg::*;

  logic     ihit;
  logic     dhit;
  logic     mem_dREN;
  logic     mem_dWEN;
  logic     mem_redirect;
  logic     idex_MemRead;
  regbits_t idex_rd;
  regbits_t ifid_rs;
  regbits_t ifid_rt;
  logic     wb_halt;

  logic     pc_WEN;
  logic     ifid_WEN;
  logic     idex_WEN;
  logic     exmem_WEN;
  logic     memwb_WEN;
  logic     ifid_flush;
  logic     idex_flush;
  logic     exmem_flush;
  logic     memwb_flush;
  logic     halted;

  // Controller side.
  modport master (
    input  ihit, dhit, mem_dREN, mem_dWEN, mem_redirect, idex_MemRead,
           idex_rd, ifid_rs, ifid_rt, wb_halt,
    output pc_WEN, ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN,
           ifid_flush, idex_flush, exmem_flush, memwb_flush, halted
  );

  // Datapath side.
  modport slave (
    output ihit, dhit, mem_dREN, mem_dWEN, mem_redirect, idex_MemRead,
           idex_rd, ifid_rs, ifid_rt, wb_halt,
    input  pc_WEN, ifid_WEN, idex_WEN, exmem_WEN, memwb_WEN,
           ifid_flush, idex_flush, exmem_flush, memwb_flush, halted
  );

endinterface

// File: rtl/pl_hazard_ctrl_loaduse.sv
// Combinational load-use detector: a load in ID/EX writing a register the IF/ID instruction reads.
module pl_loaduse_detect
  import cpu_types_pkg::*;
(
  input  logic     idex_MemRead,
  input  regbits_t idex_rd,
  input  regbits_t ifid_rs,
  input  regbits_t ifid_rt,
  output logic     lu_hazard
);

  // $zero is never a real dependency.
  assign lu_hazard = idex_MemRead && (idex_rd != 5'd0) &&
                     ((idex_rd == ifid_rs) || (idex_rd == ifid_rt));

endmodule

// File: rtl/pl_hazard_ctrl.sv
// Pipeline sequencing controller: Mealy WEN/flush/pc_WEN generation with RUN/DWAIT/HALTED FSM.
// Optional PL_HAZARD_PERF_EN adds stall_cycles / flush_events counters.
module pl_hazard_ctrl
  import cpu_types_pkg::*;
(
  input  logic              CLK,
  input  logic              nRST,
  pl_hazard_ctrl_if.master  hz,
  output hz_state_t         dbg_state,
  output logic              dbg_ihit_held
`ifdef PL_HAZARD_PERF_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_events
`endif
);

  hz_state_t state, next_state;
  logic      ihit_held, ihit_held_next;
  logic      lu_hazard;
  logic      dmem_wait;
  logic      redirect_win;
  logic      pc_w, ifid_w, idex_w, exmem_w, memwb_w;
  logic      ifid_f, idex_f, exmem_f, memwb_f;

  pl_loaduse_detect u_loaduse (
    .idex_MemRead (hz.idex_MemRead),
    .idex_rd      (hz.idex_rd),
    .ifid_rs      (hz.ifid_rs),
    .ifid_rt      (hz.ifid_rt),
    .lu_hazard    (lu_hazard)
  );

  assign dmem_wait = (hz.mem_dREN | hz.mem_dWEN) & ~hz.dhit;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= RUN;
      ihit_held <= 1'b0;
    end else begin
      state     <= next_state;
      ihit_held <= ihit_held_next;
    end
  end

  always_comb begin
    next_state     = state;
    ihit_held_next = ihit_held;
    redirect_win   = 1'b0;
    pc_w    = 1'b0; ifid_w  = 1'b0; idex_w  = 1'b0; exmem_w = 1'b0; memwb_w = 1'b0;
    ifid_f  = 1'b0; idex_f  = 1'b0; exmem_f = 1'b0; memwb_f = 1'b0;
    if (state != HALTED) begin
      if (dmem_wait) begin
        next_state = DWAIT;
        if (hz.ihit) ihit_held_next = 1'b1;
      end else begin
        next_state = RUN;
        if (hz.mem_redirect) begin
          redirect_win = 1'b1;
          pc_w    = 1'b1;
          memwb_w = 1'b1;
          ifid_f  = 1'b1; idex_f = 1'b1; exmem_f = 1'b1;
        end else if (lu_hazard) begin
          exmem_w = 1'b1; memwb_w = 1'b1;
          idex_f  = 1'b1;
          if (hz.ihit) ihit_held_next = 1'b1;
        end else if (!(hz.ihit || ihit_held)) begin
          idex_w = 1'b1; exmem_w = 1'b1; memwb_w = 1'b1;
          ifid_f = 1'b1;
        end else begin
          pc_w = 1'b1; ifid_w = 1'b1; idex_w = 1'b1; exmem_w = 1'b1; memwb_w = 1'b1;
        end
      end
      if (hz.wb_halt) next_state = HALTED;
    end
    // A PC advance or redirect consumes (or discards) the held fetch.
    if (pc_w || hz.mem_redirect) ihit_held_next = 1'b0;
  end

  assign hz.pc_WEN      = pc_w;
  assign hz.ifid_WEN    = ifid_w;
  assign hz.idex_WEN    = idex_w;
  assign hz.exmem_WEN   = exmem_w;
  assign hz.memwb_WEN   = memwb_w;
  assign hz.ifid_flush  = ifid_f;
  assign hz.idex_flush  = idex_f;
  assign hz.exmem_flush = exmem_f;
  assign hz.memwb_flush = memwb_f;
  assign hz.halted      = (state == HALTED);
  assign dbg_state      = state;
  assign dbg_ihit_held  = ihit_held;

`ifdef PL_HAZARD_PERF_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cycles <= 32'd0;
      flush_events <= 32'd0;
    end else if (state != HALTED) begin
      if (!pc_w)        stall_cycles <= stall_cycles + 32'd1;
      if (redirect_win) flush_events <= flush_events + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pl_hazard_ctrl.sv
// Self-checking bench for pl_hazard_ctrl: directed scenarios plus randomized traffic against a rule-table model.
module tb_pl_hazard_ctrl;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  pl_hazard_ctrl_if hz ();
  hz_state_t dbg_state;
  logic      dbg_ihit_held;
`ifdef PL_HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  pl_hazard_ctrl dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .hz            (hz.master),
    .dbg_state     (dbg_state),
    .dbg_ihit_held (dbg_ihit_held)
`ifdef PL_HAZARD_PERF_EN
    ,
    .stall_cycles  (stall_cycles),
    .flush_events  (flush_events)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Reference model: mode 0 = running, 1 = waiting on dmem, 2 = halted.
  int          m_mode;
  bit          m_held;
  logic [31:0] m_stall;
  logic [31:0] m_flush;

  // Vector order: pc, ifid_w, idex_w, exmem_w, memwb_w, ifid_f, idex_f, exmem_f, memwb_f
  localparam logic [8:0] V_STALL = 9'b000000000;
  localparam logic [8:0] V_REDIR = 9'b100011110;
  localparam logic [8:0] V_LU    = 9'b000110100;
  localparam logic [8:0] V_FWAIT = 9'b001111000;
  localparam logic [8:0] V_RUN   = 9'b111110000;

  function automatic int rule_of();
    if (m_mode == 2) return 0;
    if ((hz.mem_dREN || hz.mem_dWEN) && !hz.dhit) return 1;
    if (hz.mem_redirect) return 2;
    if (hz.idex_MemRead && hz.idex_rd != 0 &&
        (hz.idex_rd == hz.ifid_rs || hz.idex_rd == hz.ifid_rt)) return 3;
    if (!(hz.ihit || m_held)) return 4;
    return 5;
  endfunction

  function automatic logic [8:0] exp_vec(int r);
    case (r)
      2:       return V_REDIR;
      3:       return V_LU;
      4:       return V_FWAIT;
      5:       return V_RUN;
      default: return V_STALL;
    endcase
  endfunction

  function automatic hz_state_t exp_state();
    if (m_mode == 2) return HALTED;
    if (m_mode == 1) return DWAIT;
    return RUN;
  endfunction

  function automatic logic [8:0] dut_vec();
    return {hz.pc_WEN, hz.ifid_WEN, hz.idex_WEN, hz.exmem_WEN, hz.memwb_WEN,
            hz.ifid_flush, hz.idex_flush, hz.exmem_flush, hz.memwb_flush};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_held = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic set_in(input bit ihit, input bit dhit, input bit dren, input bit dwen,
                        input bit redir, input bit memread, input logic [4:0] rd,
                        input logic [4:0] rs, input logic [4:0] rt, input bit halt);
    hz.ihit = ihit; hz.dhit = dhit; hz.mem_dREN = dren; hz.mem_dWEN = dwen;
    hz.mem_redirect = redir; hz.idex_MemRead = memread;
    hz.idex_rd = rd; hz.ifid_rs = rs; hz.ifid_rt = rt; hz.wb_halt = halt;
  endtask

  // Advance one clock and the model with it; returns at posedge + 1.
  task automatic tick();
    int r;
    logic [8:0] e;
    r = rule_of();
    e = exp_vec(r);
    @(posedge CLK);
    if (m_mode != 2 && !e[8]) m_stall = m_stall + 32'd1;
    if (r == 2) m_flush = m_flush + 32'd1;
    if (e[8] || hz.mem_redirect) m_held = 0;
    else if (hz.ihit && (r == 1 || r == 3)) m_held = 1;
    if (m_mode != 2) begin
      if (hz.wb_halt) m_mode = 2;
      else m_mode = (r == 1) ? 1 : 0;
    end
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    checks++;
    if (dbg_state !== RUN) begin
      failures++; $display("FAIL reset_state got=%0d want=%0d", dbg_state, RUN);
    end
    checks++;
    if (dbg_ihit_held !== 1'b0 || hz.halted !== 1'b0) begin
      failures++; $display("FAIL reset_flags held=%b halted=%b want 0/0", dbg_ihit_held, hz.halted);
    end
    checks++;
    if (dut_vec() !== V_RUN) begin
      failures++; $display("FAIL reset_ctrl got=%b want=%b", dut_vec(), V_RUN);
    end
    @(posedge CLK); @(posedge CLK); #1;
    nRST = 1'b1;
  endtask

  task automatic test_load_use();
    // lw $3 in ID/EX, add $4,$3,$1 in IF/ID
    set_in(1, 0, 0, 0, 0, 1, 5'd3, 5'd3, 5'd1, 0);
    #3; checks++;
    if (dut_vec() !== V_LU) begin
      failures++; $display("FAIL load_use_bubble got=%b want=%b", dut_vec(), V_LU);
    end
    tick();
    set_in(1, 0, 0, 0, 0, 0, 5'd0, 5'd4, 5'd3, 0);
    #3; checks++;
    if (dut_vec() !== V_RUN) begin
      failures++; $display("FAIL load_use_resume got=%b want=%b", dut_vec(), V_RUN);
    end
    tick();
    // $zero destination is not a hazard
    set_in(1, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0);
    #3; checks++;
    if (dut_vec() !== V_RUN) begin
      failures++; $display("FAIL load_use_zero got=%b want=%b", dut_vec(), V_RUN);
    end
    tick();
  endtask

  task automatic test_dwait();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      #3; checks++;
      if (dut_vec() !== V_STALL) begin
        failures++; $display("FAIL dwait_stall[%0d] got=%b want=%b", i, dut_vec(), V_STALL);
      end
      tick();
      checks++;
      if (dbg_state !== DWAIT) begin
        failures++; $display("FAIL dwait_state[%0d] got=%0d want=%0d", i, dbg_state, DWAIT);
      end
    end
    set_in(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    #3; checks++;
    if (dut_vec() !== V_RUN) begin
      failures++; $display("FAIL dwait_release got=%b want=%b", dut_vec(), V_RUN);
    end
    tick();
    checks++;
    if (dbg_state !== RUN) begin
      failures++; $display("FAIL dwait_exit got=%0d want=%0d", dbg_state, RUN);
    end
  endtask

  task automatic test_redirect();
    set_in(1, 0, 0, 0, 1, 1, 5'd7, 5'd7, 5'd2, 0);
    #3; checks++;
    if (dut_vec() !== V_REDIR) begin
      failures++; $display("FAIL redirect_wins got=%b want=%b", dut_vec(), V_REDIR);
    end
    tick();
    // store waiting on dmem outranks redirect
    set_in(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    #3; checks++;
    if (dut_vec() !== V_STALL) begin
      failures++; $display("FAIL redirect_vs_dwait got=%b want=%b", dut_vec(), V_STALL);
    end
    tick();
    set_in(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_ihit_held();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3; checks++;
    if (dut_vec() !== V_FWAIT) begin
      failures++; $display("FAIL fetch_wait got=%b want=%b", dut_vec(), V_FWAIT);
    end
    tick();
    set_in(1, 0, 0, 0, 0, 1, 5'd9, 5'd1, 5'd9, 0);
    tick();
    checks++;
    if (dbg_ihit_held !== 1'b1) begin
      failures++; $display("FAIL ihit_held_set got=%b want=1", dbg_ihit_held);
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3; checks++;
    if (dut_vec() !== V_RUN) begin
      failures++; $display("FAIL ihit_held_advance got=%b want=%b", dut_vec(), V_RUN);
    end
    tick();
    checks++;
    if (dbg_ihit_held !== 1'b0) begin
      failures++; $display("FAIL ihit_held_clear got=%b want=0", dbg_ihit_held);
    end
  endtask

  task automatic test_halt();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #3; checks++;
    if (dut_vec() !== V_RUN || hz.halted !== 1'b0) begin
      failures++; $display("FAIL halt_cycle got=%b halted=%b want=%b halted=0", dut_vec(), hz.halted, V_RUN);
    end
    tick();
    for (int i = 0; i < 10; i++) begin
      set_in($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 0,
             $urandom_range(0, 1), 1, 5'd2, 5'd2, 5'd2, 0);
      #3; checks++;
      if (dut_vec() !== V_STALL || hz.halted !== 1'b1 || dbg_state !== HALTED) begin
        failures++;
        $display("FAIL halt_hold[%0d] got=%b halted=%b state=%0d want=%b halted=1 state=%0d",
                 i, dut_vec(), hz.halted, dbg_state, V_STALL, HALTED);
      end
      tick();
    end
    #2 nRST = 1'b0;
    model_reset();
    #1; checks++;
    if (hz.halted !== 1'b0 || dbg_state !== RUN) begin
      failures++; $display("FAIL halt_reset halted=%b state=%0d want 0/%0d", hz.halted, dbg_state, RUN);
    end
    @(posedge CLK); #1;
    nRST = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 7) == 0, $urandom_range(0, 1),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 0);
      #3; checks++;
      if (dut_vec() !== exp_vec(rule_of())) begin
        failures++; $display("FAIL rand_ctrl[%0d] got=%b want=%b", i, dut_vec(), exp_vec(rule_of()));
      end
      tick();
      checks++;
      if (dbg_state !== exp_state() || dbg_ihit_held !== m_held) begin
        failures++;
        $display("FAIL rand_state[%0d] state=%0d held=%b want state=%0d held=%b",
                 i, dbg_state, dbg_ihit_held, exp_state(), m_held);
      end
`ifdef PL_HAZARD_PERF_EN
      checks++;
      if (stall_cycles !== m_stall || flush_events !== m_flush) begin
        failures++;
        $display("FAIL rand_perf[%0d] stall=%0d flush=%0d want %0d/%0d",
                 i, stall_cycles, flush_events, m_stall, m_flush);
      end
`endif
    end
  endtask

`ifdef PL_HAZARD_PERF_EN
  task automatic test_perf();
    checks++;
    if (stall_cycles !== 32'd0 || flush_events !== 32'd0) begin
      failures++; $display("FAIL perf_reset stall=%0d flush=%0d want 0/0", stall_cycles, flush_events);
    end
    for (int i = 0; i < 5; i++) begin set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick(); end
    for (int i = 0; i < 2; i++) begin set_in(1, 0, 0, 0, 1, 0, 0, 0, 0, 0); tick(); end
    checks++;
    if (stall_cycles !== 32'd5 || flush_events !== 32'd2) begin
      failures++; $display("FAIL perf_count stall=%0d flush=%0d want 5/2", stall_cycles, flush_events);
    end
  endtask
`endif

  initial begin
    @(posedge CLK); #1;
    test_reset();
`ifdef PL_HAZARD_PERF_EN
    test_perf();
`endif
    test_load_use();
    test_dwait();
    test_redirect();
    test_ihit_held();
    test_halt();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pl_hazard_ctrl.md
# pl_hazard_ctrl

Pipeline sequencing controller for the five-stage pipeline: generates the write-enable and flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC. It resolves data-memory waits, instruction-fetch waits, load-use hazards, MEM-stage control redirects and halt. It sits beside the datapath and is the only driver of every pipe-register `WEN`/`flush` and `pc_WEN`.

## Interface
Parameters: none.
- `CLK`  in  1  system clock, rising edge.
- `nRST`  in  1  reset, asynchronous, active-low.
- `ihit`  in  1  instruction memory returned fetch data this cycle.
- `dhit`  in  1  data memory completed the MEM-stage access this cycle.
- `mem_dREN`, `mem_dWEN`  in  1 each  EX/MEM stage holds a load / store.
- `mem_redirect`  in  1  branch taken or jump resolved in MEM.
- `idex_MemRead`  in  1  ID/EX holds a load.
- `idex_rd`  in  5  destination register of the ID/EX instruction.
- `ifid_rs`, `ifid_rt`  in  5 each  source registers of the IF/ID instruction.
- `wb_halt`  in  1  `halt_out` of MEM/WB.
- `pc_WEN`  out  1  PC update enable.
- `ifid_WEN`, `idex_WEN`, `exmem_WEN`, `memwb_WEN`  out  1 each  pipe-register enables.
- `ifid_flush`, `idex_flush`, `exmem_flush`, `memwb_flush`  out  1 each  pipe-register bubble insert (clears control only).
- `halted`  out  1  sticky halt indication.

## Operation
- States: RUN, DWAIT, HALTED. Reset: RUN, `ihit_held`=0.
- Outputs are Mealy: functions of state, `ihit_held`, current inputs. Flush is asserted only when the same register is meant to capture a bubble; flush and WEN of one register are never both 1.
- Priority each cycle in RUN/DWAIT (first match wins):
  1. Dmem wait: (`mem_dREN`|`mem_dWEN`) & !`dhit` -> all WEN 0, all flush 0, `pc_WEN`=0; next DWAIT.
  2. Redirect: `mem_redirect` -> `pc_WEN`=1, `ifid_flush`=`idex_flush`=`exmem_flush`=1, `memwb_WEN`=1.
  3. Load-use: `idex_MemRead` & `idex_rd`!=0 & (`idex_rd`==`ifid_rs` | `idex_rd`==`ifid_rt`) -> `pc_WEN`=0, `ifid_WEN`=0, `idex_flush`=1, `exmem_WEN`=`memwb_WEN`=1.
  4. Fetch wait: !(`ihit`|`ihit_held`) -> `pc_WEN`=0, `ifid_flush`=1, others WEN=1.
  5. Otherwise all WEN=1, `pc_WEN`=1, flushes 0.
- DWAIT: on `dhit`, evaluate rules 2-5 as in RUN this cycle, next RUN.
- `ihit_held`: set when `ihit` arrives while rule 1 or 3 blocks `pc_WEN`; cleared on any cycle with `pc_WEN`=1 or `mem_redirect`. Prevents a lost fetch when I-hit and stall coincide.
- `wb_halt`=1 in any state -> next HALTED. HALTED: all WEN, flush, `pc_WEN` 0; `halted`=1; exit only by reset. In the `wb_halt` cycle itself outputs follow rules 1-5.
- Reset mid-stall: state returns RUN, `ihit_held` clears, counters clear; no pending access is remembered.

## Timing
- Zero-cycle decision latency: controls valid in the same cycle as inputs; registers update on the next rising `CLK`.
- Load-use inserts exactly one bubble; redirect costs three squashed slots; dmem wait stalls N cycles for N cycles of !`dhit`.
- `halted` rises the cycle after `wb_halt` is sampled.

## Configuration
- `PL_HAZARD_PERF_EN`: defined -> adds outputs `stall_cycles` (32) and `flush_events` (32). `stall_cycles` increments every cycle with `pc_WEN`=0 in RUN/DWAIT; `flush_events` increments once per rule-2 cycle. Both wrap at 2^32-1 -> 0, reset to 0, freeze in HALTED. Undefined -> ports and counters absent, behaviour otherwise identical.

## Structure
- `cpu_types_pkg`: `hz_state_t` enum (RUN, DWAIT, HALTED), `regbits_t` (5-bit register index).
- Sub-module `pl_loaduse_detect`: combinational load-use compare, one output `lu_hazard`.

## Test plan
- Load `lw $3`, then `add $4,$3,$1` -> one cycle `idex_flush`=1, `pc_WEN`=0, `ifid_WEN`=0; next cycle all WEN=1.
- `mem_dREN`=1, `dhit` low 3 cycles -> 3 cycles all controls 0, state DWAIT; `dhit` cycle all WEN=1, state RUN.
- `mem_redirect`=1 with simultaneous load-use -> redirect wins: three flushes, `pc_WEN`=1.
- `ihit`=1 during a load-use cycle -> `ihit_held`=1; next cycle `ihit`=0 still advances PC, `ihit_held` clears.
- `wb_halt`=1 -> next cycle `halted`=1, all controls 0, holds 10 cycles; `nRST` pulse -> `halted`=0, RUN.
- With `PL_HAZARD_PERF_EN`: preload `stall_cycles`=0xFFFFFFFF via stalls-forced run, one stall -> 0.
